// File: rtl/quad_velocity_error.sv
// Quadrature encoder decoder producing per-period signed velocity and a
// saturated, registered velocity error (setpoint - velocity) with a sample strobe.
module quad_velocity_error #(
   parameter int W           = 15,
   parameter int SAMPLE_DIV  = 20000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enc_a,
   input  logic                enc_b,
   input  logic signed [W:0]   setpoint,
   output logic signed [W:0]   e_out,
   output logic signed [W:0]   velocity,
   output logic                sample_valid,
   output logic                quad_err
);
   localparam int CW      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int PRIME_N = SYNC_STAGES + 1;
   localparam int PW      = $clog2(PRIME_N + 1);
   localparam logic [CW-1:0] TC         = CW'(SAMPLE_DIV - 1);
   localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_N);

   logic [SYNC_STAGES-1:0] a_sync_q;
   logic [SYNC_STAGES-1:0] b_sync_q;
   logic [1:0]             prev_q;
   logic [PW-1:0]          prime_q;
   logic [CW-1:0]          cnt_q;
   logic signed [W:0]      acc_q;
   logic signed [W:0]      vel_q;
   logic signed [W:0]      err_q;
   logic                   valid_q;
   logic                   qerr_q;

   logic [1:0]             cur_ab;
   logic [1:0]             cur_pos;
   logic [1:0]             prev_pos;
   logic [1:0]             step;
   logic                   primed;
   logic                   illegal;
   logic signed [W+1:0]    delta;
   logic signed [W+1:0]    acc_sum;
   logic signed [W+1:0]    diff;
   logic signed [W:0]      vel_d;
   logic signed [W:0]      err_d;

   // Any W+2 bit sum of two W+1 bit words fits, so overflow shows as a top-bit mismatch.
   function automatic logic signed [W:0] sat(input logic signed [W+1:0] x);
      if (x[W+1] == x[W]) return x[W:0];
      return x[W+1] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
   endfunction

   assign cur_ab   = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
   // Gray-to-binary turns the quadrature state into a position modulo 4.
   assign cur_pos  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
   assign prev_pos = {prev_q[1], prev_q[1] ^ prev_q[0]};
   assign primed   = (prime_q == PRIME_DONE);

   always_comb begin
      step    = cur_pos - prev_pos;
      delta   = '0;
      illegal = 1'b0;
      if (primed) begin
         case (step)
            2'd1:    delta = {{(W+1){1'b0}}, 1'b1};
            2'd3:    delta = '1;
            2'd2:    illegal = 1'b1;
            default: delta = '0;
         endcase
      end
   end

   assign acc_sum = {acc_q[W], acc_q} + delta;
   assign vel_d   = sat(acc_sum);
   assign diff    = {setpoint[W], setpoint} - {vel_d[W], vel_d};
   assign err_d   = sat(diff);

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sync_q <= '0;
         b_sync_q <= '0;
         prev_q   <= 2'b00;
         prime_q  <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         vel_q    <= '0;
         err_q    <= '0;
         valid_q  <= 1'b0;
         qerr_q   <= 1'b0;
      end else begin
         a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
         b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
         prev_q   <= cur_ab;
         if (!primed) prime_q <= prime_q + PW'(1);
         if (illegal) qerr_q <= 1'b1;
         if (cnt_q == TC) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            vel_q   <= vel_d;
            err_q   <= err_d;
            valid_q <= 1'b1;
         end else begin
            cnt_q   <= cnt_q + CW'(1);
            acc_q   <= vel_d;
            valid_q <= 1'b0;
         end
      end
   end

   assign e_out        = err_q;
   assign velocity     = vel_q;
   assign sample_valid = valid_q;
   assign quad_err     = qerr_q;

endmodule

// File: tb/tb_quad_velocity_error.sv
// Bench for quad_velocity_error: two instances (wide/short period and narrow/long
// period) share encoder pins; a pin-history model predicts every output each cycle.
module tb_quad_velocity_error;
   localparam int SS  = 2;
   localparam int W0  = 15;
   localparam int SD0 = 100;
   localparam int W1  = 7;
   localparam int SD1 = 1000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic enc_a = 1'b0;
   logic enc_b = 1'b0;
   logic signed [W0:0] sp0 = '0;
   logic signed [W1:0] sp1 = '0;

   logic signed [W0:0] e_out0, velocity0;
   logic               sample_valid0, quad_err0;
   logic signed [W1:0] e_out1, velocity1;
   logic               sample_valid1, quad_err1;

   int n_vec = 0;
   int n_bad = 0;
   int pos   = 0;

   logic [1:0] hist[$];
   int         n_cyc = 0;
   longint     macc[2];
   longint     mvel[2];
   longint     merr[2];
   bit         mvalid[2];
   bit         mqerr;

   quad_velocity_error #(.W(W0), .SAMPLE_DIV(SD0), .SYNC_STAGES(SS)) u_dut0 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .setpoint(sp0),
      .e_out(e_out0), .velocity(velocity0), .sample_valid(sample_valid0), .quad_err(quad_err0));

   quad_velocity_error #(.W(W1), .SAMPLE_DIV(SD1), .SYNC_STAGES(SS)) u_dut1 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .setpoint(sp1),
      .e_out(e_out1), .velocity(velocity1), .sample_valid(sample_valid1), .quad_err(quad_err1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] seq_ab(input int p);
      case (p)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int quad_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic longint clampw(input longint x, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< w) - 1;
      lo = -(longint'(1) <<< w);
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   // Reference: a pin change first visible in cycle m lands in the period holding cycle m+SS.
   task automatic model_step();
      int     d;
      int     df;
      int     wv;
      int     sdv;
      longint v;
      longint sp;
      if (reset) begin
         n_cyc = 0;
         hist.delete();
         mqerr = 1'b0;
         for (int i = 0; i < 2; i++) begin
            macc[i] = 0; mvel[i] = 0; merr[i] = 0; mvalid[i] = 1'b0;
         end
         return;
      end
      hist.push_back({enc_a, enc_b});
      if (hist.size() > SS + 2) void'(hist.pop_front());
      d = 0;
      if (n_cyc >= SS + 1) begin
         df = (quad_pos(hist[1]) - quad_pos(hist[0]) + 4) % 4;
         if (df == 1) d = 1;
         else if (df == 3) d = -1;
         else if (df == 2) mqerr = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         wv  = (i == 0) ? W0 : W1;
         sdv = (i == 0) ? SD0 : SD1;
         sp  = (i == 0) ? longint'(sp0) : longint'(sp1);
         v   = clampw(macc[i] + d, wv);
         if (n_cyc % sdv == sdv - 1) begin
            mvel[i]   = v;
            merr[i]   = clampw(sp - v, wv);
            macc[i]   = 0;
            mvalid[i] = 1'b1;
         end else begin
            macc[i]   = v;
            mvalid[i] = 1'b0;
         end
      end
      n_cyc++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("valid0", 64'(sample_valid0), longint'(mvalid[0]));
         chk("vel0",   64'($signed(velocity0)), mvel[0]);
         chk("err0",   64'($signed(e_out0)), merr[0]);
         chk("qerr0",  64'(quad_err0), longint'(mqerr));
         chk("valid1", 64'(sample_valid1), longint'(mvalid[1]));
         chk("vel1",   64'($signed(velocity1)), mvel[1]);
         chk("err1",   64'($signed(e_out1)), merr[1]);
         chk("qerr1",  64'(quad_err1), longint'(mqerr));
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d n_bad=%0d", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic drive_pos();
      logic [1:0] ab;
      ab    = seq_ab(pos);
      enc_a = ab[1];
      enc_b = ab[0];
   endtask

   task automatic step(input int s);
      pos = (pos + s + 4) % 4;
      drive_pos();
   endtask

   task automatic do_reset(input int k, input int p);
      @(negedge clk);
      reset = 1'b1;
      pos   = p;
      drive_pos();
      tick(k);
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int idx, output int cyc);
      logic v;
      cyc = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cyc++;
         v = (idx == 0) ? sample_valid0 : sample_valid1;
         if (v === 1'b1) return;
      end
      n_vec++;
      n_bad++;
      $display("FAIL valid_wait%0d: no sample_valid within %0d cycles", idx, cyc);
   endtask

   initial begin
      int cyc;
      int r;
      drive_pos();
      tick(5);
      chk("rst_e_out", 64'($signed(e_out0)), 0);
      chk("rst_vel",   64'($signed(velocity0)), 0);
      chk("rst_valid", 64'(sample_valid0), 0);
      chk("rst_qerr",  64'(quad_err0), 0);
      reset = 1'b0;

      // Idle encoder, zero setpoint
      wait_valid(0, cyc);
      chk("t1_latency", 64'(cyc), SD0);
      chk("t1_vel", 64'($signed(velocity0)), 0);
      chk("t1_err", 64'($signed(e_out0)), 0);
      wait_valid(0, cyc);
      chk("t1_period", 64'(cyc), SD0);
      chk("t1_qerr", 64'(quad_err0), 0);

      // 40 forward counts against setpoint 50, then an empty period
      do_reset(3, pos);
      sp0 = 16'sd50;
      tick(1);
      for (int i = 0; i < 40; i++) begin step(1); tick(2); end
      wait_valid(0, cyc);
      chk("t2_vel", 64'($signed(velocity0)), 40);
      chk("t2_err", 64'($signed(e_out0)), 10);
      wait_valid(0, cyc);
      chk("t2_vel_idle", 64'($signed(velocity0)), 0);
      chk("t2_err_idle", 64'($signed(e_out0)), 50);

      // 25 reverse counts against setpoint -10
      sp0 = -16'sd10;
      for (int i = 0; i < 25; i++) begin step(-1); tick(2); end
      wait_valid(0, cyc);
      chk("t3_vel", 64'($signed(velocity0)), -25);
      chk("t3_err", 64'($signed(e_out0)), 15);

      // Narrow instance: error and accumulator saturation
      do_reset(3, pos);
      sp1 = 8'sd100;
      tick(1);
      for (int i = 0; i < 100; i++) begin step(-1); tick(2); end
      wait_valid(1, cyc);
      chk("t4_vel", 64'($signed(velocity1)), -100);
      chk("t4_err_hi", 64'($signed(e_out1)), 127);
      sp1 = 8'h80;
      for (int i = 0; i < 10; i++) begin step(1); tick(2); end
      wait_valid(1, cyc);
      chk("t4_vel_b", 64'($signed(velocity1)), 10);
      chk("t4_err_lo", 64'($signed(e_out1)), -128);
      sp1 = '0;
      for (int i = 0; i < 200; i++) begin step(1); tick(2); end
      wait_valid(1, cyc);
      chk("t4_acc_sat", 64'($signed(velocity1)), 127);
      chk("t4_err_c", 64'($signed(e_out1)), -127);

      // Illegal double-bit change, sticky flag, cleared by reset with A=B=1 held
      do_reset(3, pos);
      sp0 = '0;
      tick(5);
      step(2);
      wait_valid(0, cyc);
      chk("t5_qerr", 64'(quad_err0), 1);
      chk("t5_vel", 64'($signed(velocity0)), 0);
      wait_valid(0, cyc);
      chk("t5_qerr_sticky", 64'(quad_err0), 1);
      chk("t5_qerr_sticky1", 64'(quad_err1), 1);
      do_reset(3, 2);
      wait_valid(0, cyc);
      chk("t5_qerr_clr", 64'(quad_err0), 0);
      chk("t5_vel_11", 64'($signed(velocity0)), 0);

      // Count decoded in the TC cycle belongs to the ending period; next one to the new period
      do_reset(2, pos);
      tick(97);
      step(1);
      tick(1);
      step(1);
      wait_valid(0, cyc);
      chk("t6_tc_vel", 64'($signed(velocity0)), 1);
      chk("t6_tc_err", 64'($signed(e_out0)), -1);
      wait_valid(0, cyc);
      chk("t6_next_vel", 64'($signed(velocity0)), 1);

      // Reset at period cycle 50 after 20 edges
      for (int i = 0; i < 20; i++) begin step(1); tick(2); end
      tick(10);
      do_reset(1, pos);
      wait_valid(0, cyc);
      chk("t6_rst_latency", 64'(cyc), SD0);
      chk("t6_rst_vel", 64'($signed(velocity0)), 0);

      // Randomized traffic
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 1499) == 0) do_reset($urandom_range(1, 4), pos);
         if ($urandom_range(0, 49) == 0) begin
            sp0 = 16'($urandom);
            sp1 = 8'($urandom);
         end
         r = $urandom_range(0, 399);
         if (r < 90) step(1);
         else if (r < 160) step(-1);
         else if (r == 399) step(2);
      end
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
